// File: rtl/rvfi_check_scheduler.sv
// rvfi_check_scheduler: sequences one formal check run.
// Holds the DUT in reset, waits out a warm-up window, then fires a single
// cycle `check` strobe when the configured order retires on the configured
// channel. Also reports retire count and done/missed/timeout status.
// Optional order monitor enabled by defining RVFI_CHECK_SCHED_ORDER_MON_EN;
// without it order_err is tied low and no tracking logic exists.
module rvfi_check_scheduler #(
  parameter int NRET         = 1,
  parameter int RESET_CYCLES = 1,
  parameter int MIN_CYCLE    = 10,
  parameter int MAX_CYCLE    = 40,
  parameter int CNT_W        = 16,
  localparam int CH_W        = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [63:0]         cfg_order,
  input  logic [CH_W-1:0]     cfg_channel,
  input  logic [NRET-1:0]     rvfi_valid,
  input  logic [64*NRET-1:0]  rvfi_order,
  output logic                dut_reset,
  output logic                check,
  output logic                done,
  output logic                missed,
  output logic                timeout,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic                order_err
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_WARMUP,
    ST_ARMED,
    ST_DONE
  } state_t;

  state_t            state;
  logic [RST_W-1:0]  rst_cnt;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [63:0]       order_q;
  logic [CH_W-1:0]   chan_q;
  logic              match;
  logic [CNT_W:0]    pop;
  logic [CNT_W:0]    retire_sum;
  logic [CNT_W-1:0]  retire_next;

  // Target retirement seen on the latched channel with the latched order.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if ((CH_W'(i) == chan_q) && rvfi_valid[i] &&
          (rvfi_order[64*i +: 64] == order_q)) begin
        match = 1'b1;
      end
    end
  end

  // Count valid retirements this cycle and form the saturated running total.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NRET; i++) begin
      pop = pop + {{CNT_W{1'b0}}, rvfi_valid[i]};
    end
    retire_sum  = {1'b0, retire_cnt} + pop;
    retire_next = retire_sum[CNT_W] ? {CNT_W{1'b1}} : retire_sum[CNT_W-1:0];
  end

  assign dut_reset = (state == ST_RESET);
  assign check     = (state == ST_ARMED) && match;

  // Run sequencer: reset window, warm-up, armed window, absorbing done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RESET;
      rst_cnt    <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      order_q    <= '0;
      chan_q     <= '0;
      done       <= 1'b0;
      missed     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (state != ST_RESET) begin
        if (cycle_cnt != {CNT_W{1'b1}}) begin
          cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
        retire_cnt <= retire_next;
      end
      case (state)
        ST_RESET: begin
          if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
            order_q   <= cfg_order;
            chan_q    <= cfg_channel;
            rst_cnt   <= '0;
            cycle_cnt <= '0;
            state     <= ST_WARMUP;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        ST_WARMUP: begin
          if (match) begin
            missed <= 1'b1;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else if (cycle_cnt == CNT_W'(MIN_CYCLE - 1)) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (match) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (cycle_cnt == CNT_W'(MAX_CYCLE)) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

`ifdef RVFI_CHECK_SCHED_ORDER_MON_EN
  logic [63:0] next_order;
  logic [63:0] mon_adv;
  logic        mon_bad;
  logic        mon_gap;
  logic        order_err_q;

  // Valid channels must be contiguous from channel 0 and carry consecutive orders.
  always_comb begin
    mon_adv = '0;
    mon_bad = 1'b0;
    mon_gap = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        if (mon_gap) begin
          mon_bad = 1'b1;
        end
        if (rvfi_order[64*i +: 64] != (next_order + mon_adv)) begin
          mon_bad = 1'b1;
        end
        mon_adv = mon_adv + 64'd1;
      end else begin
        mon_gap = 1'b1;
      end
    end
  end

  // Track expected next order and hold the sticky error once seen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      next_order  <= '0;
      order_err_q <= 1'b0;
    end else if (state != ST_RESET) begin
      next_order <= next_order + mon_adv;
      if (mon_bad) begin
        order_err_q <= 1'b1;
      end
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_check_scheduler.sv
// Directed testbench for rvfi_check_scheduler (NRET=2, RESET_CYCLES=2,
// MIN_CYCLE=10, MAX_CYCLE=40). Cycle index c counts from dut_reset release.
module tb_rvfi_check_scheduler;

  logic         clock;
  logic         reset_n;
  logic [63:0]  cfg_order;
  logic [0:0]   cfg_channel;
  logic [1:0]   rvfi_valid;
  logic [127:0] rvfi_order;
  logic         dut_reset;
  logic         check;
  logic         done;
  logic         missed;
  logic         timeout;
  logic [15:0]  retire_cnt;
  logic         order_err;

  int checks;
  int failures;

  rvfi_check_scheduler #(
    .NRET(2), .RESET_CYCLES(2), .MIN_CYCLE(10), .MAX_CYCLE(40), .CNT_W(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cfg_order(cfg_order),
    .cfg_channel(cfg_channel), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .dut_reset(dut_reset), .check(check), .done(done), .missed(missed),
    .timeout(timeout), .retire_cnt(retire_cnt), .order_err(order_err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // mode 0: ch0 order=c; 1: ch0=2c, ch1=2c+1; 2: ch0 valid order 21, ch1 invalid 21; 3: orders 0,1,3,4..
  task automatic applyStimulus(input int mode, input int c);
    case (mode)
      0: begin rvfi_valid = 2'b01; rvfi_order[63:0] = 64'(c); rvfi_order[127:64] = 64'd0; end
      1: begin rvfi_valid = 2'b11; rvfi_order[63:0] = 64'(2*c); rvfi_order[127:64] = 64'(2*c+1); end
      2: begin rvfi_valid = 2'b01; rvfi_order[63:0] = 64'd21; rvfi_order[127:64] = 64'd21; end
      default: begin
        rvfi_valid = 2'b01;
        rvfi_order[63:0] = (c < 2) ? 64'(c) : 64'(c+1);
        rvfi_order[127:64] = 64'd0;
      end
    endcase
  endtask

  // Reset, with the target order presented on both channels during the reset window.
  task automatic start_run(input logic [63:0] ord, input logic ch);
    reset_n     = 1'b0;
    cfg_order   = ord;
    cfg_channel = ch;
    rvfi_valid  = 2'b11;
    rvfi_order  = {ord, ord};
    #2;
    reset_n = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cfg_order = 64'd3; cfg_channel = 1'b0;
    rvfi_valid = 2'b11; rvfi_order = {64'd3, 64'd3};
    #1;
    checks++; if (dut_reset !== 1'b1) begin failures++; $display("[TB] FAIL reset_dut_reset got %0b want 1", dut_reset); end
    checks++; if (check !== 1'b0) begin failures++; $display("[TB] FAIL reset_check got %0b want 0", check); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %0b want 0", done); end
    checks++; if (missed !== 1'b0) begin failures++; $display("[TB] FAIL reset_missed got %0b want 0", missed); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout got %0b want 0", timeout); end
    checks++; if (retire_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_retire_cnt got %0d want 0", retire_cnt); end
    checks++; if (order_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_order_err got %0b want 0", order_err); end
    #1;
    reset_n = 1'b1;
    #1;
    checks++; if (dut_reset !== 1'b1) begin failures++; $display("[TB] FAIL rel_dut_reset0 got %0b want 1", dut_reset); end
    next_cycle();
    checks++; if (dut_reset !== 1'b1) begin failures++; $display("[TB] FAIL rel_dut_reset1 got %0b want 1", dut_reset); end
    checks++; if (check !== 1'b0) begin failures++; $display("[TB] FAIL rel_check1 got %0b want 0", check); end
    next_cycle();
    checks++; if (dut_reset !== 1'b0) begin failures++; $display("[TB] FAIL rel_dut_reset2 got %0b want 0", dut_reset); end
    checks++; if (retire_cnt !== 16'd0) begin failures++; $display("[TB] FAIL rel_retire_cnt got %0d want 0", retire_cnt); end
    checks++; if (missed !== 1'b0) begin failures++; $display("[TB] FAIL rel_missed got %0b want 0", missed); end
  endtask

  task automatic test_missed();
    start_run(64'd5, 1'b0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, c);
      #3;
      checks++; if (check !== 1'b0) begin failures++; $display("[TB] FAIL missed_check c=%0d got %0b want 0", c, check); end
      checks++; if (missed !== (c >= 6)) begin failures++; $display("[TB] FAIL missed_flag c=%0d got %0b want %0b", c, missed, (c >= 6)); end
      checks++; if (done !== (c >= 6)) begin failures++; $display("[TB] FAIL missed_done c=%0d got %0b want %0b", c, done, (c >= 6)); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL missed_timeout c=%0d got %0b want 0", c, timeout); end
      next_cycle();
    end
  endtask

  task automatic test_fire();
    start_run(64'd15, 1'b0);
    for (int c = 0; c < 21; c++) begin
      applyStimulus(0, c);
      #3;
      checks++; if (check !== (c == 15)) begin failures++; $display("[TB] FAIL fire_check c=%0d got %0b want %0b", c, check, (c == 15)); end
      checks++; if (done !== (c >= 16)) begin failures++; $display("[TB] FAIL fire_done c=%0d got %0b want %0b", c, done, (c >= 16)); end
      checks++; if (missed !== 1'b0 || timeout !== 1'b0) begin failures++; $display("[TB] FAIL fire_status c=%0d got missed=%0b timeout=%0b want 0/0", c, missed, timeout); end
      checks++; if (retire_cnt !== 16'(c)) begin failures++; $display("[TB] FAIL fire_retire_cnt c=%0d got %0d want %0d", c, retire_cnt, c); end
      checks++; if (order_err !== 1'b0) begin failures++; $display("[TB] FAIL fire_order_err c=%0d got %0b want 0", c, order_err); end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    start_run(64'd100, 1'b0);
    for (int c = 0; c < 44; c++) begin
      applyStimulus(0, c);
      #3;
      checks++; if (check !== 1'b0) begin failures++; $display("[TB] FAIL timeout_check c=%0d got %0b want 0", c, check); end
      checks++; if (timeout !== (c >= 41)) begin failures++; $display("[TB] FAIL timeout_flag c=%0d got %0b want %0b", c, timeout, (c >= 41)); end
      checks++; if (done !== (c >= 41)) begin failures++; $display("[TB] FAIL timeout_done c=%0d got %0b want %0b", c, done, (c >= 41)); end
      next_cycle();
    end
  endtask

  task automatic test_timeout_edge();
    start_run(64'd40, 1'b0);
    for (int c = 0; c < 44; c++) begin
      applyStimulus(0, c);
      #3;
      checks++; if (check !== (c == 40)) begin failures++; $display("[TB] FAIL edge_check c=%0d got %0b want %0b", c, check, (c == 40)); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL edge_timeout c=%0d got %0b want 0", c, timeout); end
      checks++; if (done !== (c >= 41)) begin failures++; $display("[TB] FAIL edge_done c=%0d got %0b want %0b", c, done, (c >= 41)); end
      next_cycle();
    end
  endtask

  task automatic test_dual_channel();
    start_run(64'd21, 1'b1);
    for (int c = 0; c < 15; c++) begin
      applyStimulus(1, c);
      #3;
      checks++; if (check !== (c == 10)) begin failures++; $display("[TB] FAIL dual_check c=%0d got %0b want %0b", c, check, (c == 10)); end
      checks++; if (done !== (c >= 11)) begin failures++; $display("[TB] FAIL dual_done c=%0d got %0b want %0b", c, done, (c >= 11)); end
      checks++; if (retire_cnt !== 16'(2*c)) begin failures++; $display("[TB] FAIL dual_retire_cnt c=%0d got %0d want %0d", c, retire_cnt, 2*c); end
      checks++; if (order_err !== 1'b0) begin failures++; $display("[TB] FAIL dual_order_err c=%0d got %0b want 0", c, order_err); end
      next_cycle();
    end
  endtask

  task automatic test_wrong_channel();
    start_run(64'd21, 1'b1);
    for (int c = 0; c < 16; c++) begin
      applyStimulus(2, c);
      #3;
      checks++; if (check !== 1'b0) begin failures++; $display("[TB] FAIL wrongch_check c=%0d got %0b want 0", c, check); end
      checks++; if (done !== 1'b0 || missed !== 1'b0) begin failures++; $display("[TB] FAIL wrongch_status c=%0d got done=%0b missed=%0b want 0/0", c, done, missed); end
      next_cycle();
    end
  endtask

  task automatic test_midrun_reset();
    start_run(64'd11, 1'b0);
    for (int c = 0; c < 13; c++) begin
      applyStimulus(0, c);
      #3;
      checks++; if (check !== (c == 11)) begin failures++; $display("[TB] FAIL mid_check c=%0d got %0b want %0b", c, check, (c == 11)); end
      checks++; if (done !== (c >= 12)) begin failures++; $display("[TB] FAIL mid_done c=%0d got %0b want %0b", c, done, (c >= 12)); end
      if (c < 12) next_cycle();
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (dut_reset !== 1'b1) begin failures++; $display("[TB] FAIL mid_async_dut_reset got %0b want 1", dut_reset); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_done got %0b want 0", done); end
    checks++; if (retire_cnt !== 16'd0) begin failures++; $display("[TB] FAIL mid_async_retire_cnt got %0d want 0", retire_cnt); end
    checks++; if (check !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_check got %0b want 0", check); end
    cfg_order = 64'd12;
    cfg_channel = 1'b0;
    #1;
    reset_n = 1'b1;
    next_cycle();
    next_cycle();
    for (int c = 0; c < 15; c++) begin
      applyStimulus(0, c);
      #3;
      checks++; if (check !== (c == 12)) begin failures++; $display("[TB] FAIL restart_check c=%0d got %0b want %0b", c, check, (c == 12)); end
      checks++; if (done !== (c >= 13)) begin failures++; $display("[TB] FAIL restart_done c=%0d got %0b want %0b", c, done, (c >= 13)); end
      checks++; if (retire_cnt !== 16'(c)) begin failures++; $display("[TB] FAIL restart_retire_cnt c=%0d got %0d want %0d", c, retire_cnt, c); end
      next_cycle();
    end
  endtask

  task automatic test_order_mon();
    logic mon_on;
`ifdef RVFI_CHECK_SCHED_ORDER_MON_EN
    mon_on = 1'b1;
`else
    mon_on = 1'b0;
`endif
    start_run(64'd1000, 1'b0);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(3, c);
      #3;
      checks++; if (order_err !== (mon_on && (c >= 3))) begin failures++; $display("[TB] FAIL order_skip c=%0d got %0b want %0b", c, order_err, (mon_on && (c >= 3))); end
      next_cycle();
    end
    start_run(64'd1000, 1'b0);
    rvfi_valid = 2'b10;
    rvfi_order = {64'd0, 64'd0};
    #3;
    checks++; if (order_err !== 1'b0) begin failures++; $display("[TB] FAIL order_gap_pre got %0b want 0", order_err); end
    next_cycle();
    rvfi_valid = 2'b00;
    #3;
    checks++; if (order_err !== mon_on) begin failures++; $display("[TB] FAIL order_gap got %0b want %0b", order_err, mon_on); end
    next_cycle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    cfg_order = '0;
    cfg_channel = '0;
    rvfi_valid = '0;
    rvfi_order = '0;
    next_cycle();
    test_reset();
    test_missed();
    test_fire();
    test_timeout();
    test_timeout_edge();
    test_dual_channel();
    test_wrong_channel();
    test_midrun_reset();
    test_order_mon();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
